// File: rtl/pipeline_pkg.sv
// Shared pipeline constants, fetch FSM encodings and the IF/ID payload type.
package pipeline_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Fetch FSM encodings
    localparam int unsigned STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_RUN  = 1'b0;
    localparam logic [STATE_W-1:0] ST_HALT = 1'b1;

    // Contents of one IF/ID slot
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    // PC of the next sequential instruction, wrapping mod 2^XLEN
    function automatic logic [XLEN-1:0] pc_plus_step(input logic [XLEN-1:0] pc);
        return pc + XLEN'(PC_STEP);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: squash beats hold beats load.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        squash,
    input  logic [31:0] pc,
    input  logic [31:0] pc4,
    input  logic [31:0] instr,
    input  logic        valid,
    output logic [31:0] q_pc,
    output logic [31:0] q_pc4,
    output logic [31:0] q_instr,
    output logic        q_valid
);

    if_id_t slot_q;
    if_id_t slot_d;

    // Squash keeps the PC fields and turns the slot into a bubble
    always_comb begin
        slot_d = slot_q;
        if (squash) begin
            slot_d.instr = NOP_INSTR;
            slot_d.valid = 1'b0;
        end else if (!hold) begin
            slot_d.pc    = pc;
            slot_d.pc4   = pc4;
            slot_d.instr = instr;
            slot_d.valid = valid;
        end
    end

    // Slot register with synchronous reset to an empty bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q.pc    <= '0;
            slot_q.pc4   <= '0;
            slot_q.instr <= NOP_INSTR;
            slot_q.valid <= 1'b0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_pc    = slot_q.pc;
    assign q_pc4   = slot_q.pc4;
    assign q_instr = slot_q.instr;
    assign q_valid = slot_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, fetch fault FSM and fetch counter.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    logic [31:0]        pc_q, pc_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic               fault_q, fault_d;
    logic [31:0]        count_q, count_d;

    logic        bad_pc;
    logic        ifid_hold;
    logic        ifid_squash;
    logic [31:0] pc_next_seq;

    assign pc_next_seq = pc_plus_step(pc_q);

    // Misaligned or beyond the end of instruction memory
    assign bad_pc = (pc_q[1:0] != 2'b00) || (pc_q[31:2] >= 30'(IMEM_DEPTH));

    // Next-state: redirect > stall > fault > sequential fetch; HALT waits for a redirect
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        fault_d     = fault_q;
        count_d     = count_q;
        ifid_hold   = 1'b0;
        ifid_squash = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    ifid_squash = 1'b1;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (bad_pc) begin
                    state_d     = ST_HALT;
                    fault_d     = 1'b1;
                    ifid_squash = 1'b1;
                end else begin
                    pc_d    = pc_next_seq;
                    count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
                end
            end
            ST_HALT: begin
                ifid_squash = 1'b1;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_RUN;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_RUN;
                ifid_squash = 1'b1;
            end
        endcase
    end

    // PC, FSM, fault and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .hold    (ifid_hold),
        .squash  (ifid_squash),
        .pc      (pc_q),
        .pc4     (pc_next_seq),
        .instr   (imem_instr),
        .valid   (1'b1),
        .q_pc    (if_id_pc),
        .q_pc4   (if_id_pc4),
        .q_instr (if_id_instr),
        .q_valid (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign fetch_fault = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:255];
    int tests;
    int fails;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always_comb begin
        if (imem_addr[31:10] == 22'd0)
            imem_instr = mem[imem_addr[9:2]];
        else
            imem_instr = 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[0] = 32'h0200_2283;
        mem[1] = 32'h0100_2303;
        mem[2] = 32'h0200_2383;
        mem[3] = 32'h0062_e433;

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step();
        chk("rst_pc",    imem_addr,   32'h0);
        chk("rst_ifpc",  if_id_pc,    32'h0);
        chk("rst_ifpc4", if_id_pc4,   32'h0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_count", fetch_count, 32'd0);

        // Four sequential fetches
        reset = 1'b0;
        step();
        chk("f0_pc",    if_id_pc,    32'h0);
        chk("f0_pc4",   if_id_pc4,   32'h4);
        chk("f0_instr", if_id_instr, 32'h0200_2283);
        chk("f0_valid", 32'(if_id_valid), 32'd1);
        step();
        chk("f1_pc",    if_id_pc,    32'h4);
        chk("f1_instr", if_id_instr, 32'h0100_2303);
        step();
        chk("f2_pc",    if_id_pc,    32'h8);
        chk("f2_instr", if_id_instr, 32'h0200_2383);
        step();
        chk("f3_pc",    if_id_pc,    32'hC);
        chk("f3_instr", if_id_instr, 32'h0062_e433);
        chk("f3_count", fetch_count, 32'd4);
        chk("f3_addr",  imem_addr,   32'h10);

        // Two-edge stall holds PC, IF/ID and counter
        stall = 1'b1;
        step();
        step();
        chk("st_addr",  imem_addr,   32'h10);
        chk("st_ifpc",  if_id_pc,    32'hC);
        chk("st_instr", if_id_instr, 32'h0062_e433);
        chk("st_valid", 32'(if_id_valid), 32'd1);
        chk("st_count", fetch_count, 32'd4);
        stall = 1'b0;
        step();
        chk("rel_ifpc",  if_id_pc,    32'h10);
        chk("rel_instr", if_id_instr, 32'h1000_0004);
        chk("rel_count", fetch_count, 32'd5);

        // Redirect wins over simultaneous stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h28;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        chk("rd_addr",  imem_addr,   32'h28);
        chk("rd_valid", 32'(if_id_valid), 32'd0);
        chk("rd_instr", if_id_instr, NOP);
        chk("rd_ifpc",  if_id_pc,    32'h10);
        chk("rd_ifpc4", if_id_pc4,   32'h14);
        chk("rd_count", fetch_count, 32'd5);
        step();
        chk("rd2_ifpc",  if_id_pc,    32'h28);
        chk("rd2_instr", if_id_instr, 32'h1000_000A);
        chk("rd2_valid", 32'(if_id_valid), 32'd1);
        chk("rd2_count", fetch_count, 32'd6);

        // Last word, then run off the end of memory
        redirect_valid = 1'b1; redirect_pc = 32'h3FC;
        step();
        redirect_valid = 1'b0;
        chk("end_addr", imem_addr, 32'h3FC);
        step();
        chk("end_ifpc",  if_id_pc,    32'h3FC);
        chk("end_instr", if_id_instr, 32'h1000_00FF);
        chk("end_pc4",   if_id_pc4,   32'h400);
        chk("end_count", fetch_count, 32'd7);
        chk("end_fault0", 32'(fetch_fault), 32'd0);
        step();
        chk("oob_fault", 32'(fetch_fault), 32'd1);
        chk("oob_valid", 32'(if_id_valid), 32'd0);
        chk("oob_instr", if_id_instr, NOP);
        chk("oob_addr",  imem_addr,   32'h400);
        chk("oob_count", fetch_count, 32'd7);
        stall = 1'b1;
        step();
        stall = 1'b0;
        chk("halt_addr",  imem_addr, 32'h400);
        chk("halt_fault", 32'(fetch_fault), 32'd1);
        chk("halt_valid", 32'(if_id_valid), 32'd0);

        // Redirect out of HALT to a misaligned target re-faults
        redirect_valid = 1'b1; redirect_pc = 32'h2;
        step();
        redirect_valid = 1'b0;
        chk("mis_addr",   imem_addr, 32'h2);
        chk("mis_fault0", 32'(fetch_fault), 32'd0);
        chk("mis_valid",  32'(if_id_valid), 32'd0);
        step();
        chk("mis_fault1", 32'(fetch_fault), 32'd1);
        chk("mis_hold",   imem_addr, 32'h2);
        chk("mis_count",  fetch_count, 32'd7);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("res_fault", 32'(fetch_fault), 32'd0);
        chk("res_addr",  imem_addr, 32'h0);
        step();
        chk("res_ifpc",  if_id_pc,    32'h0);
        chk("res_instr", if_id_instr, 32'h0200_2283);
        chk("res_valid", 32'(if_id_valid), 32'd1);
        chk("res_count", fetch_count, 32'd8);

        // Run to pc=0x1C, then reset in the middle of a stall and redirect
        for (int i = 0; i < 6; i++) step();
        chk("mid_addr",  imem_addr,   32'h1C);
        chk("mid_count", fetch_count, 32'd14);
        chk("mid_ifpc",  if_id_pc,    32'h18);
        reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        chk("rst2_addr",  imem_addr,   32'h0);
        chk("rst2_count", fetch_count, 32'd0);
        chk("rst2_valid", 32'(if_id_valid), 32'd0);
        chk("rst2_fault", 32'(fetch_fault), 32'd0);
        chk("rst2_ifpc",  if_id_pc,    32'h0);
        chk("rst2_instr", if_id_instr, NOP);
        step();
        chk("post_ifpc",  if_id_pc,    32'h0);
        chk("post_count", fetch_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
